// File: rtl/ctrl_slave_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_slave_arbiter
// Description : Round-robin arbiter sharing the controller slave register port
//               between two requesters, with a watchdog on controller acks.
// Revision    : 1.0 - initial release
// ============================================================================
module ctrl_slave_arbiter #(
    parameter int ADDR_WIDTH     = 36,
    parameter int DATA_WIDTH     = 128,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TIMEOUT_WIDTH  = 11
) (
    input  logic                  router_clk1,
    input  logic                  router_rst,
    input  logic [ADDR_WIDTH-1:0] req0_address,
    input  logic                  req0_wrreq,
    input  logic                  req0_rdreq,
    input  logic [DATA_WIDTH-1:0] req0_datain,
    output logic                  req0_wrack,
    output logic                  req0_rdack,
    output logic [DATA_WIDTH-1:0] req0_dataout,
    output logic                  req0_error,
    input  logic [ADDR_WIDTH-1:0] req1_address,
    input  logic                  req1_wrreq,
    input  logic                  req1_rdreq,
    input  logic [DATA_WIDTH-1:0] req1_datain,
    output logic                  req1_wrack,
    output logic                  req1_rdack,
    output logic [DATA_WIDTH-1:0] req1_dataout,
    output logic                  req1_error,
    output logic [ADDR_WIDTH-1:0] controller_slave_address,
    output logic                  controller_slave_wrreq,
    input  logic                  controller_slave_wrack,
    output logic [DATA_WIDTH-1:0] controller_slave_datain,
    output logic                  controller_slave_rdreq,
    input  logic                  controller_slave_rdack,
    input  logic [DATA_WIDTH-1:0] controller_slave_dataout
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RESPOND = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam logic [TIMEOUT_WIDTH-1:0] c_to_last = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [TIMEOUT_WIDTH-1:0] c_one     = TIMEOUT_WIDTH'(1);

    state_t                  state_q, state_d;
    logic                    ptr_q, ptr_d;
    logic                    grant_q, grant_d;
    logic                    rnw_q, rnw_d;
    logic                    err_q, err_d;
    logic                    wr_q, wr_d;
    logic                    rd_q, rd_d;
    logic [TIMEOUT_WIDTH-1:0] cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   dout0_q, dout0_d;
    logic [DATA_WIDTH-1:0]   dout1_q, dout1_d;

    logic                    w_pend0, w_pend1, w_sel, w_sel_wr, w_hit, w_respond;
    logic [DATA_WIDTH-1:0]   w_rdata;

    assign w_pend0   = req0_wrreq | req0_rdreq;
    assign w_pend1   = req1_wrreq | req1_rdreq;
    // Pointer only matters when both are pending; otherwise the lone requester wins.
    assign w_sel     = (w_pend0 & w_pend1) ? ptr_q : w_pend1;
    assign w_sel_wr  = w_sel ? req1_wrreq : req0_wrreq;
    assign w_hit     = rnw_q ? controller_slave_rdack : controller_slave_wrack;
    assign w_rdata   = w_hit ? controller_slave_dataout : '0;
    assign w_respond = (state_q == RESPOND);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        rnw_d   = rnw_q;
        err_d   = err_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        dout0_d = dout0_q;
        dout1_d = dout1_q;
        case (state_q)
            IDLE: begin
                if (w_pend0 || w_pend1) begin
                    grant_d = w_sel;
                    rnw_d   = !w_sel_wr;
                    wr_d    = w_sel_wr;
                    rd_d    = !w_sel_wr;
                    addr_d  = w_sel ? req1_address : req0_address;
                    wdata_d = w_sel ? req1_datain : req0_datain;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                // A matching ack on the last allowed cycle still counts as a real ack.
                if (w_hit || (cnt_q == c_to_last)) begin
                    wr_d  = 1'b0;
                    rd_d  = 1'b0;
                    err_d = !w_hit;
                    if (rnw_q) begin
                        if (grant_q) begin
                            dout1_d = w_rdata;
                        end else begin
                            dout0_d = w_rdata;
                        end
                    end
                    state_d = RESPOND;
                end else begin
                    cnt_d = cnt_q + c_one;
                end
            end
            RESPOND: begin
                ptr_d   = ~grant_q;
                state_d = RELEASE;
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge router_clk1) begin
        if (!router_rst) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            grant_q <= 1'b0;
            rnw_q   <= 1'b0;
            err_q   <= 1'b0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            dout0_q <= '0;
            dout1_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            rnw_q   <= rnw_d;
            err_q   <= err_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            dout0_q <= dout0_d;
            dout1_q <= dout1_d;
        end
    end

    assign controller_slave_address = addr_q;
    assign controller_slave_datain  = wdata_q;
    assign controller_slave_wrreq   = wr_q;
    assign controller_slave_rdreq   = rd_q;

    assign req0_wrack   = w_respond & !grant_q & !rnw_q;
    assign req0_rdack   = w_respond & !grant_q & rnw_q;
    assign req0_error   = w_respond & !grant_q & err_q;
    assign req0_dataout = dout0_q;
    assign req1_wrack   = w_respond & grant_q & !rnw_q;
    assign req1_rdack   = w_respond & grant_q & rnw_q;
    assign req1_error   = w_respond & grant_q & err_q;
    assign req1_dataout = dout1_q;

endmodule
`default_nettype wire

// File: doc/ctrl_slave_arbiter.md
Name: ctrl_slave_arbiter

Overview:
Round-robin arbiter that shares the single controller slave register port (36-bit address, 128-bit data, wrreq/rdreq with wrack/rdack) between two requesters, disk0 and disk1 slave-side agents. It sits in the router between the per-disk SAP logic and the controller. Each access is held as a locked transaction until the controller acknowledges it. A watchdog terminates hung accesses with an error.

Parameters:
ADDR_WIDTH, 36, address width on all ports
DATA_WIDTH, 128, data width on all ports
TIMEOUT_CYCLES, 1024, cycles to wait for controller ack before forced completion
TIMEOUT_WIDTH, 11, counter width; must hold TIMEOUT_CYCLES

Ports:
router_clk1  in  1  single clock; all logic rising-edge
router_rst  in  1  synchronous, active-low reset
reqN_address  in  ADDR_WIDTH  requester N address (N=0,1, same for all reqN_* ports)
reqN_wrreq  in  1  requester N write request, level, held until reqN_wrack
reqN_rdreq  in  1  requester N read request, level, held until reqN_rdack
reqN_datain  in  DATA_WIDTH  requester N write data
reqN_wrack  out  1  one-cycle write completion pulse
reqN_rdack  out  1  one-cycle read completion pulse
reqN_dataout  out  DATA_WIDTH  read data, valid with reqN_rdack
reqN_error  out  1  timeout flag, valid with the ack pulse
controller_slave_address  out  ADDR_WIDTH  registered address to controller
controller_slave_wrreq  out  1  write strobe, held until controller_slave_wrack
controller_slave_wrack  in  1  controller write ack
controller_slave_datain  out  DATA_WIDTH  registered write data
controller_slave_rdreq  out  1  read strobe, held until controller_slave_rdack
controller_slave_rdack  in  1  controller read ack
controller_slave_dataout  in  DATA_WIDTH  controller read data, valid with rdack

Behaviour:
- Reset (router_rst=0 at edge): state=IDLE, priority pointer=0, timeout counter=0. All outputs are 0, including strobes, acks, errors, address and data. Reset mid-transaction aborts the transaction: no ack is issued and controller strobes drop at that edge.
- FSM states: IDLE, ACCESS, RESPOND, RELEASE.
- IDLE:
  - Requester N is pending if reqN_wrreq or reqN_rdreq is high.
  - If both are pending, grant the one equal to the priority pointer.
  - On grant, register address, datain and rnw, then go to ACCESS.
  - If a requester has wrreq and rdreq high together, it is a write (rdreq ignored).
- ACCESS:
  - controller_slave_wrreq or controller_slave_rdreq is high the first cycle after grant, i.e. 1 cycle after the request is sampled.
  - It stays high until the matching ack is sampled.
  - An ack of the wrong type (e.g. rdack during a write) is ignored.
  - On the matching ack: drop the strobe next cycle, capture controller_slave_dataout for reads, then go to RESPOND.
- Timeout: the counter increments each ACCESS cycle. When it reaches TIMEOUT_CYCLES-1 with no ack, drop the strobe, set error, force read data to 0, and go to RESPOND.
- RESPOND:
  - Pulse exactly one cycle of reqN_wrack or reqN_rdack for the granted N.
  - Drive reqN_error (1 only on timeout) and reqN_dataout during that pulse.
  - Set the priority pointer to the other requester, then go to RELEASE.
- RELEASE: one dead cycle, so the requester's still-high request is not re-granted. Then go to IDLE.
- Latency: controller ack at cycle M gives requester ack at M+1. Back-to-back grant is sampled at M+3 and the next controller strobe rises at M+4.
- reqN_dataout holds its last value between reads; it is only meaningful with rdack.
- Fairness: with both requesters continuously pending, grants strictly alternate 0,1,0,1.

Test Plan:
- Single write: req0 write addr 0x0_0000_0010, data 0xA5..A5; controller wrack 3 cycles later -> controller_slave_wrreq high for 4 cycles with matching addr/data; req0_wrack single pulse one cycle after wrack; req0_error=0.
- Single read: req1 read addr 0x20; controller rdack with data 0x1234 -> req1_rdack pulse with req1_dataout=0x1234 one cycle after rdack.
- Contention: req0 and req1 both write from reset, each controller ack after 1 cycle -> grant order 0,1,0,1 across 4 transactions; no ack is duplicated.
- Timeout: req0 read, controller never acks, TIMEOUT_CYCLES=16 -> rdreq drops after 16 ACCESS cycles; req0_rdack with req0_error=1 and dataout=0; the next request is serviced normally.
- Reset mid-access: assert router_rst=0 during ACCESS -> all strobes and acks are 0 next edge; no ack is issued; after release, the pointer is 0 and req0 wins.
- Wrong-type ack and simultaneous wr+rd: req0 asserts both, controller gives rdack then wrack -> access is treated as a write; rdack is ignored; a single req0_wrack follows the wrack.
